// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store front end between the datapath and a 64-bit data RAM. Turns
// byte-addressed byte/half/word/dword requests into doubleword RAM accesses.
// Sub-doubleword stores are done as read-modify-write; loads are lane-extracted
// and zero- or sign-extended. Misaligned or out-of-range requests return an
// error without touching the RAM.
//
// Optional feature macro: MEM_ACCESS_STATS_EN (adds stat_loads/stat_stores/
// stat_errs saturating 32-bit counters).
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we/req_size/req_signed  store flag, size (00 B, 01 H, 10 W, 11 D), sign-extend
//   req_addr/req_wdata          byte address, right-justified store data
//   resp_valid/resp_ready       response handshake (held until accepted)
//   resp_rdata/resp_err         load result, error flag
//   ram_address/ram_read_en/ram_write_en/ram_data_in  registered RAM controls
//   ram_out                     RAM read data (combinational from ram_address)
//   stat_loads/stat_stores/stat_errs  (MEM_ACCESS_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] ram_address,
    output logic        ram_read_en,
    output logic        ram_write_en,
    output logic [63:0] ram_data_in,
    input  logic [63:0] ram_out
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_errs
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t           state, state_n;
    logic             lat_we, lat_we_n;
    logic [1:0]       lat_size, lat_size_n;
    logic             lat_signed, lat_signed_n;
    logic [2:0]       lat_off, lat_off_n;
    logic [63:0]      lat_wdata, lat_wdata_n;
    logic             resp_valid_n, resp_err_n;
    logic [63:0]      resp_rdata_n;
    logic [63:0]      ram_address_n, ram_data_in_n;
    logic             ram_read_en_n, ram_write_en_n;
    logic             misaligned, out_of_range;
    logic [2:0]       align_mask;

    // Field mask for an access of the given size, right-justified.
    function automatic logic [63:0] field_mask(input logic [1:0] size);
        case (size)
            2'b00:   field_mask = 64'h0000_0000_0000_00FF;
            2'b01:   field_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   field_mask = 64'h0000_0000_FFFF_FFFF;
            default: field_mask = '1;
        endcase
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] word, input logic [1:0] size,
                                            input logic [2:0] off, input logic sgn);
        logic [63:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   extract = sgn ? {{56{sh[7]}}, sh[7:0]}   : {56'd0, sh[7:0]};
            2'b01:   extract = sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
            2'b10:   extract = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
            default: extract = word;
        endcase
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] word, input logic [63:0] wdata,
                                          input logic [1:0] size, input logic [2:0] off);
        logic [63:0] fm, lm;
        fm    = field_mask(size);
        lm    = fm << {off, 3'b000};
        merge = (word & ~lm) | ((wdata & fm) << {off, 3'b000});
    endfunction

    always_comb begin
        case (req_size)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        misaligned   = (req_addr[2:0] & align_mask) != 3'b000;
        out_of_range = req_addr[63:3] >= 61'(DEPTH);
    end

    assign req_ready = (state == IDLE);

    always_comb begin
        state_n        = state;
        lat_we_n       = lat_we;
        lat_size_n     = lat_size;
        lat_signed_n   = lat_signed;
        lat_off_n      = lat_off;
        lat_wdata_n    = lat_wdata;
        resp_valid_n   = resp_valid;
        resp_err_n     = resp_err;
        resp_rdata_n   = resp_rdata;
        ram_address_n  = ram_address;
        ram_data_in_n  = ram_data_in;
        ram_read_en_n  = 1'b0;
        ram_write_en_n = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_we_n     = req_we;
                    lat_size_n   = req_size;
                    lat_signed_n = req_signed;
                    lat_off_n    = req_addr[2:0];
                    lat_wdata_n  = req_wdata;
                    if (misaligned || out_of_range) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                    end else begin
                        ram_address_n = 64'(req_addr[IDX_W+2:3]);
                        if (req_we && req_size == 2'b11) begin
                            state_n        = WR;
                            ram_write_en_n = 1'b1;
                            ram_data_in_n  = req_wdata;
                        end else begin
                            state_n       = RD;
                            ram_read_en_n = 1'b1;
                        end
                    end
                end
            end
            // ram_out is valid this cycle because ram_address was registered on accept.
            RD: begin
                if (lat_we) begin
                    state_n        = WR;
                    ram_write_en_n = 1'b1;
                    ram_data_in_n  = merge(ram_out, lat_wdata, lat_size, lat_off);
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_rdata_n = extract(ram_out, lat_size, lat_off, lat_signed);
                end
            end
            WR: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_err_n   = 1'b0;
                resp_rdata_n = '0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b0;
                    resp_err_n   = 1'b0;
                    resp_rdata_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_we       <= 1'b0;
            lat_size     <= '0;
            lat_signed   <= 1'b0;
            lat_off      <= '0;
            lat_wdata    <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            ram_address  <= '0;
            ram_data_in  <= '0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
        end else begin
            state        <= state_n;
            lat_we       <= lat_we_n;
            lat_size     <= lat_size_n;
            lat_signed   <= lat_signed_n;
            lat_off      <= lat_off_n;
            lat_wdata    <= lat_wdata_n;
            resp_valid   <= resp_valid_n;
            resp_err     <= resp_err_n;
            resp_rdata   <= resp_rdata_n;
            ram_address  <= ram_address_n;
            ram_data_in  <= ram_data_in_n;
            ram_read_en  <= ram_read_en_n;
            ram_write_en <= ram_write_en_n;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    logic resp_fire;
    assign resp_fire = (state == RESP) && resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (resp_fire) begin
            if (resp_err) begin
                if (stat_errs != '1) stat_errs <= stat_errs + 32'd1;
            end else if (lat_we) begin
                if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
            end else begin
                if (stat_loads != '1) stat_loads <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] ram_address;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [63:0] ram_data_in;
  logic [63:0] ram_out;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;
  logic [31:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int overlap = 0;
  int rd_snap;
  int wr_snap;
  logic preload;
  logic [63:0] mem [0:31];

  mem_access_unit #(.DEPTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_address(ram_address),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_data_in(ram_data_in), .ram_out(ram_out)
`ifdef MEM_ACCESS_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ram_out = '0;
    if (ram_address < 64'd32) ram_out = mem[ram_address[4:0]];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int unsigned i = 0; i < 32; i++) mem[i] <= 64'(i * 100);
    end else if (ram_write_en && ram_address < 64'd32) begin
      mem[ram_address[4:0]] <= ram_data_in;
    end
    if (ram_read_en) rd_pulses++;
    if (ram_write_en) wr_pulses++;
    if (ram_read_en && ram_write_en) overlap++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
    req_we     = ~we;
    req_size   = ~sz;
    req_signed = ~sg;
    req_addr   = '1;
    req_wdata  = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_valid_drop", 64'(resp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  task automatic load(input logic [1:0] sz, input logic sg, input logic [63:0] a,
                      input logic [63:0] exp_data, input string tag);
    issue(1'b0, sz, sg, a, '0);
    chk("ld_rd_en", 64'(ram_read_en), 64'd1);
    chk("ld_addr", ram_address, 64'(a[63:3]));
    chk("ld_no_resp_yet", 64'(resp_valid), 64'd0);
    step();
    chk("ld_resp_valid", 64'(resp_valid), 64'd1);
    chk("ld_rd_en_drop", 64'(ram_read_en), 64'd0);
    chk(tag, resp_rdata, exp_data);
    chk("ld_err", 64'(resp_err), 64'd0);
    handshake();
  endtask

  task automatic err_req(input logic [1:0] sz, input logic [63:0] a, input string tag);
    rd_snap = rd_pulses;
    wr_snap = wr_pulses;
    issue(1'b0, sz, 1'b0, a, '0);
    chk(tag, 64'(resp_err), 64'd1);
    chk("err_resp_valid", 64'(resp_valid), 64'd1);
    chk("err_rdata", resp_rdata, 64'd0);
    handshake();
    chk("err_no_rd", 64'(rd_pulses), 64'(rd_snap));
    chk("err_no_wr", 64'(wr_pulses), 64'(wr_snap));
  endtask

  initial begin
    rst_n      = 1'b1;
    preload    = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = '0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_ram_address", ram_address, 64'd0);
    chk("rst_ram_read_en", 64'(ram_read_en), 64'd0);
    chk("rst_ram_write_en", 64'(ram_write_en), 64'd0);
    chk("rst_ram_data_in", ram_data_in, 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    preload = 1'b0;

    load(2'b11, 1'b0, 64'h18, 64'd300, "ld_d_0x18");
    load(2'b00, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFC8, "ld_b_s_0x10");
    load(2'b00, 1'b0, 64'h10, 64'h0000_0000_0000_00C8, "ld_b_u_0x10");
    load(2'b01, 1'b1, 64'h10, 64'h0000_0000_0000_00C8, "ld_h_s_0x10");

    issue(1'b1, 2'b00, 1'b0, 64'h21, 64'h0000_0000_0000_00AB);
    chk("stb_rd_en", 64'(ram_read_en), 64'd1);
    chk("stb_wr_en_rd", 64'(ram_write_en), 64'd0);
    step();
    chk("stb_wr_en", 64'(ram_write_en), 64'd1);
    chk("stb_rd_en_wr", 64'(ram_read_en), 64'd0);
    chk("stb_addr", ram_address, 64'd4);
    chk("stb_data_in", ram_data_in, 64'h0000_0000_0000_AB90);
    chk("stb_no_resp_yet", 64'(resp_valid), 64'd0);
    step();
    chk("stb_resp_valid", 64'(resp_valid), 64'd1);
    chk("stb_rdata", resp_rdata, 64'd0);
    chk("stb_wr_en_drop", 64'(ram_write_en), 64'd0);
    handshake();
    load(2'b11, 1'b0, 64'h20, 64'h0000_0000_0000_AB90, "ld_d_0x20");

    err_req(2'b01, 64'h23, "err_misaligned_h");
    err_req(2'b11, 64'h100, "err_range_idx32");

    issue(1'b1, 2'b10, 1'b0, 64'h34, 64'hDEAD_BEEF_89AB_CDEF);
    step();
    chk("stw_data_in", ram_data_in, 64'h89AB_CDEF_0000_0258);
    chk("stw_addr", ram_address, 64'd6);
    step();
    chk("stw_resp_valid", 64'(resp_valid), 64'd1);
    handshake();
    load(2'b10, 1'b1, 64'h34, 64'hFFFF_FFFF_89AB_CDEF, "ld_w_s_0x34");

    issue(1'b1, 2'b11, 1'b0, 64'h38, 64'h1122_3344_5566_7788);
    chk("std_wr_en", 64'(ram_write_en), 64'd1);
    chk("std_rd_en", 64'(ram_read_en), 64'd0);
    chk("std_data_in", ram_data_in, 64'h1122_3344_5566_7788);
    step();
    chk("std_resp_valid", 64'(resp_valid), 64'd1);
    handshake();
    load(2'b11, 1'b0, 64'h38, 64'h1122_3344_5566_7788, "ld_d_0x38");

    issue(1'b0, 2'b11, 1'b0, 64'h08, '0);
    step();
    for (int unsigned i = 0; i < 3; i++) begin
      chk("hold_resp_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, 64'd100);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    chk("hold_rdata_last", resp_rdata, 64'd100);
    handshake();

    chk("no_rd_wr_overlap", 64'(overlap), 64'd0);
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_loads", 64'(stat_loads), 64'd8);
    chk("stat_stores", 64'(stat_stores), 64'd3);
    chk("stat_errs", 64'(stat_errs), 64'd2);
`endif

    wr_snap = wr_pulses;
    issue(1'b1, 2'b01, 1'b0, 64'h28, 64'h0000_0000_0000_BEEF);
    chk("rst_mid_in_rd", 64'(ram_read_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", 64'(ram_write_en), 64'd0);
    chk("rst_mid_rd_en", 64'(ram_read_en), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_addr", ram_address, 64'd0);
    chk("rst_mid_data_in", ram_data_in, 64'd0);
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_no_write", 64'(wr_pulses), 64'(wr_snap));
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_loads_rst", 64'(stat_loads), 64'd0);
`endif
    load(2'b11, 1'b0, 64'h28, 64'd500, "ld_d_0x28_after_rst");
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_loads_post", 64'(stat_loads), 64'd1);
`endif
    chk("no_rd_wr_overlap_end", 64'(overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
